// File: rtl/flash_sample_streamer.sv
// flash_sample_streamer: streams packed audio samples out of an Avalon-MM flash port,
// one sample per sample_tick, with a one-word prefetch, pause, reverse and restart.
module flash_sample_streamer #(
    parameter int                ADDR_W     = 23,
    parameter int                DATA_W     = 32,
    parameter int                SAMPLE_W   = 16,
    parameter logic [ADDR_W-1:0] FIRST_ADDR = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = 'h7FFFF
) (
    input  logic                CLK_50M,
    input  logic                reset_n,
    input  logic                sample_tick,
    input  logic                pause,
    input  logic                reverse,
    input  logic                restart,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                underrun,
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    input  logic                flash_mem_waitrequest,
    input  logic [DATA_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid
);

    localparam int LANES  = DATA_W / SAMPLE_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t              state;
    state_t              state_next;

    logic [DATA_W-1:0]   cur_data;
    logic [DATA_W-1:0]   nxt_data;
    logic                cur_valid;
    logic                nxt_valid;
    logic [DATA_W-1:0]   cur_data_d;
    logic [DATA_W-1:0]   nxt_data_d;
    logic                cur_valid_d;
    logic                nxt_valid_d;

    logic [ADDR_W-1:0]   play_addr;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [LANE_W-1:0]   lane;
    logic [LANE_W-1:0]   lane_step;
    logic [LANE_W-1:0]   last_lane;

    logic                rev_q;
    logic                drain;
    logic                drop_pending;
    logic                flush;
    logic                can_fetch;
    logic                need_fetch;
    logic                tick_ok;
    logic                consume_last;
    logic                take_data;
    logic                accepted;

    logic [SAMPLE_W-1:0] cur_lanes [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign cur_lanes[g] = cur_data[g*SAMPLE_W +: SAMPLE_W];
    end

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input logic            rev);
        if (rev)
            return (a == FIRST_ADDR) ? LAST_ADDR : a - ADDR_W'(1);
        return (a == LAST_ADDR) ? FIRST_ADDR : a + ADDR_W'(1);
    endfunction

    // A direction change is seen as a difference between the live and registered level.
    assign flush      = restart || (reverse != rev_q);
    // After reset a read may still be outstanding in the controller; hold off until it drains.
    assign can_fetch  = !drain || flash_mem_readdatavalid || !flash_mem_waitrequest;
    assign need_fetch = !cur_valid || !nxt_valid;
    assign accepted   = (state == REQ) && !flash_mem_waitrequest;

    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        flash_mem_read = 1'b0;
        unique case (state)
            IDLE: begin
                if (need_fetch && !flush && can_fetch)
                    state_next = REQ;
            end
            REQ: begin
                flash_mem_read = 1'b1;
                if (!flash_mem_waitrequest)
                    state_next = (flush || drop_pending) ? DISCARD : WAIT;
            end
            WAIT: begin
                if (flash_mem_readdatavalid)
                    state_next = IDLE;
                else if (flush)
                    state_next = DISCARD;
            end
            DISCARD: begin
                if (flash_mem_readdatavalid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Consumption is applied before the incoming word, so a word landing as cur empties goes to cur.
    always_comb begin
        tick_ok      = sample_tick && !pause && !flush;
        last_lane    = reverse ? '0 : LANE_LAST;
        consume_last = tick_ok && cur_valid && (lane == last_lane);
        take_data    = (state == WAIT) && flash_mem_readdatavalid && !flush;

        if (reverse)
            lane_step = (lane == '0) ? LANE_LAST : lane - LANE_W'(1);
        else
            lane_step = (lane == LANE_LAST) ? '0 : lane + LANE_W'(1);

        cur_valid_d = cur_valid;
        cur_data_d  = cur_data;
        nxt_valid_d = nxt_valid;
        nxt_data_d  = nxt_data;

        if (consume_last) begin
            cur_valid_d = nxt_valid;
            cur_data_d  = nxt_data;
            nxt_valid_d = 1'b0;
        end

        if (take_data) begin
            if (!cur_valid_d) begin
                cur_valid_d = 1'b1;
                cur_data_d  = flash_mem_readdata;
            end else begin
                nxt_valid_d = 1'b1;
                nxt_data_d  = flash_mem_readdata;
            end
        end

        if (flush) begin
            cur_valid_d = 1'b0;
            nxt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            cur_data  <= '0;
            nxt_data  <= '0;
        end else begin
            cur_valid <= cur_valid_d;
            nxt_valid <= nxt_valid_d;
            cur_data  <= cur_data_d;
            nxt_data  <= nxt_data_d;
        end
    end

    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            rev_q        <= 1'b0;
            drain        <= 1'b1;
            drop_pending <= 1'b0;
        end else begin
            rev_q <= reverse;
            if (flash_mem_readdatavalid || !flash_mem_waitrequest)
                drain <= 1'b0;
            if (state == REQ && flash_mem_waitrequest)
                drop_pending <= drop_pending || flush;
            else
                drop_pending <= 1'b0;
        end
    end

    // A request accepted after a flush belongs to the discarded stream and must not advance fetch_addr.
    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            fetch_addr        <= FIRST_ADDR;
            flash_mem_address <= '0;
        end else begin
            if (flush)
                fetch_addr <= restart ? FIRST_ADDR : play_addr;
            else if (accepted && !drop_pending)
                fetch_addr <= step_addr(fetch_addr, reverse);

            if (state == IDLE && state_next == REQ)
                flash_mem_address <= fetch_addr;
        end
    end

    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            play_addr <= FIRST_ADDR;
            lane      <= '0;
        end else if (restart) begin
            play_addr <= FIRST_ADDR;
            lane      <= reverse ? LANE_LAST : '0;
        end else begin
            if (tick_ok && cur_valid)
                lane <= lane_step;
            if (consume_last)
                play_addr <= step_addr(play_addr, reverse);
        end
    end

    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= tick_ok && cur_valid;
            underrun     <= tick_ok && !cur_valid;
            if (pause)
                sample_out <= '0;
            else if (tick_ok)
                sample_out <= cur_valid ? cur_lanes[lane] : '0;
        end
    end

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Directed bench for flash_sample_streamer: a small Avalon flash model with adjustable
// wait states and latency, plus a playback-position model for expected samples.
module tb_flash_sample_streamer;

    localparam int ADDR_W   = 23;
    localparam int DATA_W   = 32;
    localparam int SAMPLE_W = 16;
    localparam int LAST     = 7;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                sample_tick = 1'b0;
    logic                pause = 1'b0;
    logic                reverse = 1'b0;
    logic                restart = 1'b0;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic                underrun;
    logic                flash_mem_read;
    logic [ADDR_W-1:0]   flash_mem_address;
    logic                flash_mem_waitrequest;
    logic [DATA_W-1:0]   flash_mem_readdata;
    logic                flash_mem_readdatavalid;

    int checks = 0;
    int errors = 0;
    int wait_states = 2;
    int latency = 2;
    int exp_addr = 0;
    int exp_lane = 0;
    int exp_rev = 0;

    int                ws_cnt;
    int                lat_cnt;
    logic              model_pend;
    logic [ADDR_W-1:0] pend_addr;

    flash_sample_streamer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .SAMPLE_W  (SAMPLE_W),
        .FIRST_ADDR(23'd0),
        .LAST_ADDR (23'd7)
    ) dut (
        .CLK_50M                (clk),
        .reset_n                (reset_n),
        .sample_tick            (sample_tick),
        .pause                  (pause),
        .reverse                (reverse),
        .restart                (restart),
        .sample_out             (sample_out),
        .sample_valid           (sample_valid),
        .underrun               (underrun),
        .flash_mem_read         (flash_mem_read),
        .flash_mem_address      (flash_mem_address),
        .flash_mem_waitrequest  (flash_mem_waitrequest),
        .flash_mem_readdata     (flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] exp_sample(input int a, input int l);
        return 32'(16'h100 + 2 * a + l);
    endfunction

    // Flash model: word n holds {0x100+2n+1, 0x100+2n}; reset drops any outstanding read.
    assign flash_mem_waitrequest = flash_mem_read && (ws_cnt < wait_states);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ws_cnt                  <= 0;
            lat_cnt                 <= 0;
            model_pend              <= 1'b0;
            pend_addr               <= '0;
            flash_mem_readdatavalid <= 1'b0;
            flash_mem_readdata      <= '0;
        end else begin
            flash_mem_readdatavalid <= 1'b0;
            if (flash_mem_read) begin
                if (ws_cnt < wait_states) begin
                    ws_cnt <= ws_cnt + 1;
                end else begin
                    ws_cnt     <= 0;
                    model_pend <= 1'b1;
                    pend_addr  <= flash_mem_address;
                    lat_cnt    <= latency;
                end
            end
            if (model_pend) begin
                if (lat_cnt <= 1) begin
                    flash_mem_readdatavalid <= 1'b1;
                    flash_mem_readdata <= (exp_sample(int'(pend_addr), 1) << 16)
                                        | exp_sample(int'(pend_addr), 0);
                    model_pend <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int gap);
        repeat (gap) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic advance();
        if (exp_rev == 0) begin
            if (exp_lane == 1) begin
                exp_lane = 0;
                exp_addr = (exp_addr == LAST) ? 0 : exp_addr + 1;
            end else begin
                exp_lane = 1;
            end
        end else begin
            if (exp_lane == 0) begin
                exp_lane = 1;
                exp_addr = (exp_addr == 0) ? LAST : exp_addr - 1;
            end else begin
                exp_lane = 0;
            end
        end
    endtask

    task automatic expectTick(input string tag, input int gap);
        applyStimulus(gap);
        checkOutput($sformatf("%s_valid_%0d_%0d", tag, exp_addr, exp_lane), sample_valid, 1);
        checkOutput($sformatf("%s_sample_%0d_%0d", tag, exp_addr, exp_lane), sample_out,
                    exp_sample(exp_addr, exp_lane));
        checkOutput($sformatf("%s_no_underrun", tag), underrun, 0);
        advance();
    endtask

    task automatic pulseRestart(input logic new_rev);
        @(negedge clk);
        restart = 1'b1;
        reverse = new_rev;
        @(negedge clk);
        restart = 1'b0;
        exp_addr = 0;
        exp_rev  = int'(new_rev);
        exp_lane = new_rev ? 1 : 0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ur_cnt;
        int ok_cnt;

        #5;
        checkOutput("rst_sample_out", sample_out, 0);
        checkOutput("rst_sample_valid", sample_valid, 0);
        checkOutput("rst_underrun", underrun, 0);
        checkOutput("rst_read", flash_mem_read, 0);
        checkOutput("rst_address", flash_mem_address, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // First request one cycle after release, held through two wait states.
        @(negedge clk);
        checkOutput("first_read", flash_mem_read, 1);
        checkOutput("first_address", flash_mem_address, 0);
        @(negedge clk);
        checkOutput("read_held_ws", flash_mem_read, 1);
        checkOutput("address_held_ws", flash_mem_address, 0);
        applyStimulus(0);
        checkOutput("early_underrun", underrun, 1);
        checkOutput("early_underrun_out", sample_out, 0);
        checkOutput("early_underrun_valid", sample_valid, 0);

        for (int i = 0; i < 20; i++) expectTick("fwd", 19);
        for (int i = 0; i < 5; i++) expectTick("fwd_to5", 19);
        latency = 30;
        expectTick("fwd_4H", 19);
        expectTick("fwd_5L", 19);

        // Reverse while the fetch of word 6 is still in flight.
        reverse = 1'b1;
        exp_rev = 1;
        expectTick("rev", 59);
        expectTick("rev", 39);
        expectTick("rev", 39);
        latency = 2;

        pause = 1'b1;
        @(negedge clk);
        checkOutput("pause_out_zero", sample_out, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3);
            checkOutput("pause_no_valid", sample_valid, 0);
            checkOutput("pause_no_underrun", underrun, 0);
            checkOutput("pause_out", sample_out, 0);
        end
        pause = 1'b0;
        expectTick("after_pause", 5);

        reverse = 1'b0;
        exp_rev = 0;
        expectTick("fwd_again", 20);

        @(negedge clk);
        restart     = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        restart     = 1'b0;
        sample_tick = 1'b0;
        checkOutput("restart_tick_dropped", sample_valid, 0);
        checkOutput("restart_tick_no_underrun", underrun, 0);
        exp_addr = 0;
        exp_lane = 0;
        expectTick("restart", 20);
        expectTick("restart", 19);

        pulseRestart(1'b1);
        expectTick("restart_rev", 20);
        expectTick("restart_rev", 19);
        expectTick("restart_rev_wrap", 19);

        latency = 40;
        pulseRestart(1'b0);
        ur_cnt = 0;
        ok_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(4);
            checkOutput("ur_exclusive", 32'(sample_valid ^ underrun), 1);
            if (sample_valid) begin
                checkOutput($sformatf("ur_sample_%0d_%0d", exp_addr, exp_lane), sample_out,
                            exp_sample(exp_addr, exp_lane));
                advance();
                ok_cnt++;
            end else begin
                checkOutput("ur_out_zero", sample_out, 0);
                ur_cnt++;
            end
        end
        checkOutput("ur_seen", 32'(ur_cnt > 0), 1);
        checkOutput("ur_progress", 32'(ok_cnt > 0), 1);

        latency = 2;
        pulseRestart(1'b0);
        expectTick("pre_reset", 100);
        latency = 20;
        expectTick("pre_reset", 19);
        for (int i = 0; i < 100 && !model_pend; i++) @(negedge clk);
        checkOutput("read_in_flight", model_pend, 1);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_sample_out", sample_out, 0);
        checkOutput("midrst_valid", sample_valid, 0);
        checkOutput("midrst_underrun", underrun, 0);
        checkOutput("midrst_read", flash_mem_read, 0);
        checkOutput("midrst_address", flash_mem_address, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        latency  = 2;
        exp_addr = 0;
        exp_lane = 0;
        exp_rev  = 0;
        @(negedge clk);
        checkOutput("post_rst_read", flash_mem_read, 1);
        checkOutput("post_rst_address", flash_mem_address, 0);
        expectTick("post_rst", 20);
        expectTick("post_rst", 19);
        expectTick("post_rst", 19);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
